// File: rtl/add_out_mc_pipe_pkg.sv
// Shared types and helpers for the multi-channel add_out pipeline.
// Define ADD_OUT_MC_SATURATE_EN to saturate sums (bit DATA_W then flags overflow).
package add_out_mc_pkg_hdl;

  localparam int MAX_OPERAND_W = 32;

  typedef logic [MAX_OPERAND_W:0] wide_sum_t;
  typedef logic [8:0]             fifo_entry_t;
  typedef logic [3:0]             grant_t;

  function automatic int ch_w(input int num_ch);
    int w;
    w = 0;
    while ((1 << w) < num_ch) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int lvl_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w + 1;
  endfunction

  // Operands arrive zero-extended; the caller keeps the low data_w+1 bits.
  function automatic wide_sum_t add_out_sum(input logic [MAX_OPERAND_W-1:0] a,
                                            input logic [MAX_OPERAND_W-1:0] b,
                                            input int data_w);
    wide_sum_t s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_OUT_MC_SATURATE_EN
    if (s >= (wide_sum_t'(1) << data_w))
      s = (wide_sum_t'(1) << (data_w + 1)) - wide_sum_t'(1);
`else
    s = s & ((wide_sum_t'(1) << (data_w + 1)) - wide_sum_t'(1));
`endif
    return s;
  endfunction

endpackage

// File: rtl/add_out_mc_pipe_fifo.sv
// Single-channel synchronous FIFO with occupancy output.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module add_out_mc_fifo
  import add_out_mc_pkg_hdl::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [lvl_w(DEPTH)-1:0]    level
);

  localparam int AW = lvl_w(DEPTH) - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/add_out_mc_pipe.sv
// Multi-channel add_out: per-channel adder + FIFO, round-robin merge onto one
// registered result bus. Honours ADD_OUT_MC_SATURATE_EN via add_out_sum().
module add_out_mc_pipe
  import add_out_mc_pkg_hdl::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   in_valid,
  output logic [NUM_CH-1:0]                   in_ready,
  input  logic [NUM_CH*DATA_W-1:0]            in_a,
  input  logic [NUM_CH*DATA_W-1:0]            in_b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W:0]                     out_sum,
  output logic [ch_w(NUM_CH)-1:0]             out_chan,
  output logic [NUM_CH*lvl_w(DEPTH)-1:0]      fifo_level
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W:0]   push_data [NUM_CH];
  logic [DATA_W:0]   head      [NUM_CH];

  grant_t          rr_ptr;
  grant_t          grant;
  logic            any_ne;
  logic            load;
  logic [DATA_W:0] sel_sum;

  // in_ready deliberately ignores a same-cycle pop so a full FIFO never takes a push.
  assign in_ready = reset ? ~full : '0;
  assign push     = in_valid & in_ready;
  assign load     = (!out_valid || out_ready) && any_ne;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_data[c] = (DATA_W+1)'(add_out_sum(MAX_OPERAND_W'(in_a[c*DATA_W +: DATA_W]),
                                                  MAX_OPERAND_W'(in_b[c*DATA_W +: DATA_W]),
                                                  DATA_W));
    assign pop[c] = load && (grant == grant_t'(c));

    add_out_mc_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[c]),
      .push_data (push_data[c]),
      .pop       (pop[c]),
      .head      (head[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .level     (fifo_level[c*LVL_W +: LVL_W])
    );
  end

  // Distance d from the pointer wins first; channel j sits at distance d when
  // ptr+d equals j directly or after one wrap.
  always_comb begin
    any_ne  = 1'b0;
    grant   = '0;
    sel_sum = '0;
    for (int d = 0; d < NUM_CH; d++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!any_ne && !empty[j] &&
            ((int'(rr_ptr) + d == j) || (int'(rr_ptr) + d == j + NUM_CH))) begin
          any_ne  = 1'b1;
          grant   = grant_t'(j);
          sel_sum = head[j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= sel_sum;
      out_chan  <= grant[CH_W-1:0];
      rr_ptr    <= (int'(grant) == NUM_CH - 1) ? '0 : grant + grant_t'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_out_mc_pipe.sv
// Scoreboard bench for add_out_mc_pipe (NUM_CH=4, DATA_W=8, DEPTH=4).
// Expected sums follow ADD_OUT_MC_SATURATE_EN when it is defined.
module tb_add_out_mc_pipe;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic [8:0] sum;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_sum;
  logic [1:0]  out_chan;
  logic [11:0] fifo_level;

  int   checks = 0;
  int   errors = 0;
  int   pushCount = 0;
  int   popCount = 0;
  int   maxLevel0 = 0;
  bit   trackLevel = 1'b0;
  exp_t expq[$];
  logic [1:0] obsChan[$];

  always #5 clock = ~clock;

  add_out_mc_pipe #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_chan   (out_chan),
    .fifo_level (fifo_level)
  );

  function automatic logic [8:0] satModel(input logic [8:0] plainSum);
`ifdef ADD_OUT_MC_SATURATE_EN
    return plainSum[8] ? 9'h1FF : plainSum;
`else
    return plainSum;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Holds one operand pair until accepted; the hand-computed plain sum is queued on accept.
  task automatic applyStimulus(input int ch, input logic [7:0] a, input logic [7:0] b,
                               input logic [8:0] plainSum);
    bit accepted;
    accepted = 1'b0;
    in_valid[ch]    = 1'b1;
    in_a[ch*8 +: 8] = a;
    in_b[ch*8 +: 8] = b;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clock);
      if (in_ready[ch]) begin
        accepted = 1'b1;
        expq.push_back('{ch: 2'(ch), sum: satModel(plainSum)});
        pushCount++;
      end
      @(posedge clock);
      #1;
    end
    in_valid[ch] = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget && expq.size() != 0; k++) @(posedge clock);
    checkOutput("drain_pending", expq.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: every output handshake is matched against the oldest entry of its channel.
  always @(negedge clock) begin
    int idx;
    if (reset && trackLevel && int'(fifo_level[2:0]) > maxLevel0) maxLevel0 = int'(fifo_level[2:0]);
    if (reset && out_valid && out_ready) begin
      idx = -1;
      for (int i = 0; i < expq.size(); i++)
        if (idx < 0 && expq[i].ch == out_chan) idx = i;
      obsChan.push_back(out_chan);
      popCount++;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got chan %0d sum %0d, expected none", out_chan, out_sum);
      end else begin
        checkOutput($sformatf("sum_ch%0d", out_chan), out_sum, expq[idx].sum);
        expq.delete(idx);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gaps;
    reset = 1'b0; in_valid = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    @(posedge clock); #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("run_in_ready", in_ready, 4'hF);

    // Reset mid-stream: buffered ch0 results vanish, ch1 goes first afterwards.
    applyStimulus(0, 8'd1, 8'd2, 9'd3);
    applyStimulus(0, 8'd3, 8'd4, 9'd7);
    applyStimulus(0, 8'd5, 8'd6, 9'd11);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_fifo_level", fifo_level, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    expq.delete();
    pushCount = 0;
    popCount  = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1, 8'd5, 8'd6, 9'd11);
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clock);
    checkOutput("postrst_sum", out_sum, 11);
    checkOutput("postrst_chan", out_chan, 1);
    waitDrain(20);

    // Single-channel latency: two edges from accept to visible result.
    applyStimulus(2, 8'd200, 8'd100, 9'd300);
    @(negedge clock);
    checkOutput("lat_e0_valid", out_valid, 0);
    @(negedge clock);
    checkOutput("lat_e1_valid", out_valid, 1);
    checkOutput("lat_e1_sum", out_sum, satModel(9'h12C));
    checkOutput("lat_e1_chan", out_chan, 2);
    waitDrain(20);

    // Backpressure: DEPTH in the FIFO plus one held in the output register.
    out_ready = 1'b0;
    applyStimulus(0, 8'd10, 8'd20, 9'd30);
    applyStimulus(0, 8'd100, 8'd27, 9'd127);
    applyStimulus(0, 8'd255, 8'd1, 9'd256);
    applyStimulus(0, 8'd128, 8'd128, 9'd256);
    applyStimulus(0, 8'd255, 8'd255, 9'd510);
    @(negedge clock);
    checkOutput("bp_in_ready0", in_ready[0], 0);
    checkOutput("bp_level0", fifo_level[2:0], 4);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_out_sum", out_sum, satModel(9'd30));
    repeat (3) @(negedge clock);
    checkOutput("bp_hold_sum", out_sum, satModel(9'd30));
    checkOutput("bp_hold_chan", out_chan, 0);
    checkOutput("bp_hold_ready0", in_ready[0], 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    waitDrain(40);

    // Stall stability with ch1 and ch3 active.
    out_ready = 1'b0;
    applyStimulus(1, 8'd5, 8'd6, 9'd11);
    applyStimulus(1, 8'd50, 8'd60, 9'd110);
    applyStimulus(3, 8'd7, 8'd8, 9'd15);
    applyStimulus(3, 8'd200, 8'd100, 9'd300);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    checkOutput("stall1_sum", out_sum, 15);
    checkOutput("stall1_chan", out_chan, 3);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("stall2_sum", out_sum, 15);
    checkOutput("stall2_chan", out_chan, 3);
    @(posedge clock); #1;
    out_ready = 1'b1;
    waitDrain(40);

    // Round-robin fairness with every FIFO full.
    out_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < ((c == 0) ? 5 : 4); k++)
        applyStimulus(c, 8'(c*10 + k), 8'(k), 9'(c*10 + 2*k));
    @(negedge clock);
    checkOutput("rr_levels_full", fifo_level, 12'h924);
    obsChan.delete();
    @(posedge clock); #1;
    out_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      if (!out_valid) gaps++;
    end
    checkOutput("rr_valid_gaps", gaps, 0);
    waitDrain(40);
    checkOutput("rr_count", obsChan.size(), 17);
    for (int i = 0; i < 17 && i < obsChan.size(); i++)
      checkOutput($sformatf("rr_seq%0d", i), obsChan[i], i % 4);

    // Wrap-around at full rate on ch0.
    maxLevel0  = 0;
    trackLevel = 1'b1;
    for (int i = 0; i < 3*DEPTH + 1; i++)
      applyStimulus(0, 8'(i*17), 8'(i*3 + 50), 9'(i*17) + 9'(i*3 + 50));
    waitDrain(40);
    trackLevel = 1'b0;
    checkOutput("wrap_level_over_depth", maxLevel0 > DEPTH, 0);

    checkOutput("push_pop_count", popCount, pushCount);
    checkOutput("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
